// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes/ShiftRows column-serial stage:
// S-box table, state/column widths, column type, FSM encoding and the
// ShiftRows column extractor.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef logic [31:0] column_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } subshift_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Output column c takes row r from input column (c+r) mod 4; the 2-bit
  // add wraps for free. Result is packed {row0,row1,row2,row3}.
  function automatic column_t shiftcol(input logic [STATE_W-1:0] state,
                                       input logic [1:0]         c);
    column_t    col;
    logic [1:0] src_c;
    int         bit_hi;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      src_c  = c + 2'(r);
      bit_hi = 127 - 32 * int'(src_c) - 8 * r;
      col[31-8*r -: 8] = state[bit_hi -: 8];
    end
    return col;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/subshift_colserial.sv
// AES SubBytes + ShiftRows stage. Takes one 128-bit round state per
// handshake and streams it out as four substituted, row-shifted 32-bit
// columns (0..3), one per beat, with a final-round flag alongside.
module subshift_colserial
  import aes_pkg::*;
#(
  parameter int STATE_W = 128,
  parameter int COL_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [STATE_W-1:0] s_state,
  input  logic               s_final,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COL_W-1:0]   o_column,
  output logic [1:0]         o_col_idx,
  output logic               o_last,
  output logic               o_final
);

  subshift_state_e    r_fsm;
  subshift_state_e    w_fsm_nxt;
  logic [STATE_W-1:0] r_state;
  logic               r_final;
  column_t            r_column;
  logic [1:0]         r_idx;

  logic               w_accept;
  logic               w_advance;
  logic               w_last_take;
  logic [1:0]         w_col_sel;
  logic [STATE_W-1:0] w_src;
  column_t            w_shift;
  column_t            w_sub;

  assign w_last_take = (r_fsm == EMIT) && (r_idx == 2'd3) && m_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_advance   = (r_fsm == EMIT) && m_ready && (r_idx != 2'd3);

  // On accept the first column comes straight from s_state, bypassing r_state.
  assign w_col_sel = w_accept ? 2'd0 : (r_idx + 2'd1);
  assign w_src     = w_accept ? s_state : r_state;
  assign w_shift   = shiftcol(w_src, w_col_sel);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_shift[31-8*g -: 8]),
      .o_byte (w_sub[31-8*g -: 8])
    );
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // FSM next state: leave EMIT only on the last beat with no new state waiting
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = EMIT;
      EMIT:    if (w_last_take && !w_accept) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE or on the last taken beat, for back-to-back blocks
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (r_fsm)
      IDLE: s_ready = 1'b1;
      EMIT: begin
        m_valid = 1'b1;
        s_ready = w_last_take;
      end
      default: ;
    endcase
  end

  // Capture state on accept; load next column on each taken non-last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= '0;
      r_final  <= 1'b0;
      r_column <= '0;
      r_idx    <= 2'd0;
    end else if (w_accept) begin
      r_state  <= s_state;
      r_final  <= s_final;
      r_column <= w_sub;
      r_idx    <= 2'd0;
    end else if (w_advance) begin
      r_column <= w_sub;
      r_idx    <= r_idx + 2'd1;
    end
  end

  assign o_column  = r_column;
  assign o_col_idx = r_idx;
  assign o_last    = (r_idx == 2'd3);
  assign o_final   = r_final;

endmodule

// File: tb/tb_subshift_colserial.sv
// Directed and randomized bench for subshift_colserial.
module tb_subshift_colserial;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_state;
  logic         s_final;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  o_column;
  logic [1:0]   o_col_idx;
  logic         o_last;
  logic         o_final;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [31:0]  FC0  = 32'hd4bf5d30;
  localparam logic [31:0]  FC1  = 32'he0b452ae;
  localparam logic [31:0]  FC2  = 32'hb84111f1;
  localparam logic [31:0]  FC3  = 32'h1e2798e5;
  localparam logic [31:0]  ZC   = 32'h63636363;

  always #5 clk = ~clk;

  subshift_colserial dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_state   (s_state),
    .s_final   (s_final),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .o_column  (o_column),
    .o_col_idx (o_col_idx),
    .o_last    (o_last),
    .o_final   (o_final)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] col,
                             input logic [1:0] idx, input logic last, input logic fin);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
    chk({tag, "_col"},    o_column,      col);
    chk({tag, "_idx"},    32'(o_col_idx), 32'(idx));
    chk({tag, "_last"},   32'(o_last),    32'(last));
    chk({tag, "_final"},  32'(o_final),   32'(fin));
  endtask

  // Reference S-box built from GF(2^8) inversion and the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_col(input logic [127:0] st, input int c);
    logic [31:0] col;
    int          sc;
    for (int r = 0; r < 4; r++) begin
      sc = (c + r) % 4;
      col[31-8*r -: 8] = sbox_model(st[127-32*sc-8*r -: 8]);
    end
    return col;
  endfunction

  initial begin
    logic [31:0]  q[$];
    logic [31:0]  exp_col;
    logic         acc;
    int           sent, beats, cyc;
    const int     N = 20;

    rst = 1'b1; s_valid = 1'b0; s_state = '0; s_final = 1'b0; m_ready = 1'b0;
    #3;
    chk("rst_mvalid", 32'(m_valid),   32'd0);
    chk("rst_col",    o_column,        32'd0);
    chk("rst_idx",    32'(o_col_idx),  32'd0);
    chk("rst_last",   32'(o_last),     32'd0);
    chk("rst_final",  32'(o_final),    32'd0);
    chk("rst_sready", 32'(s_ready),    32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 1: FIPS-197 round-1 state, free-flowing sink
    s_valid = 1'b1; s_state = FIPS; s_final = 1'b0; m_ready = 1'b1;
    chk("t1_sready_idle", 32'(s_ready), 32'd1);
    chk("t1_mvalid_pre",  32'(m_valid), 32'd0);
    tick();
    s_valid = 1'b0;
    expect_beat("t1_b0", FC0, 2'd0, 1'b0, 1'b0);
    chk("t1_sready_busy", 32'(s_ready), 32'd0);
    tick(); expect_beat("t1_b1", FC1, 2'd1, 1'b0, 1'b0);
    tick(); expect_beat("t1_b2", FC2, 2'd2, 1'b0, 1'b0);
    tick(); expect_beat("t1_b3", FC3, 2'd3, 1'b1, 1'b0);
    tick();
    chk("t1_idle_mvalid", 32'(m_valid), 32'd0);
    chk("t1_idle_sready", 32'(s_ready), 32'd1);

    // 2: all-zero state with final flag
    s_valid = 1'b1; s_state = '0; s_final = 1'b1;
    tick();
    s_valid = 1'b0; s_final = 1'b0;
    expect_beat("t2_b0", ZC, 2'd0, 1'b0, 1'b1);
    tick(); expect_beat("t2_b1", ZC, 2'd1, 1'b0, 1'b1);
    tick(); expect_beat("t2_b2", ZC, 2'd2, 1'b0, 1'b1);
    tick(); expect_beat("t2_b3", ZC, 2'd3, 1'b1, 1'b1);
    tick();
    chk("t2_idle_mvalid", 32'(m_valid), 32'd0);

    // 3: backpressure on column 1
    s_valid = 1'b1; s_state = FIPS; s_final = 1'b0; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    expect_beat("t3_b0", FC0, 2'd0, 1'b0, 1'b0);
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_beat("t3_hold", FC1, 2'd1, 1'b0, 1'b0);
      chk("t3_hold_sready", 32'(s_ready), 32'd0);
      tick();
    end
    expect_beat("t3_hold_end", FC1, 2'd1, 1'b0, 1'b0);
    m_ready = 1'b1;
    tick(); expect_beat("t3_b2", FC2, 2'd2, 1'b0, 1'b0);
    tick(); expect_beat("t3_b3", FC3, 2'd3, 1'b1, 1'b0);
    tick();
    chk("t3_idle_mvalid", 32'(m_valid), 32'd0);

    // 4: back-to-back blocks, second accepted on the last beat
    s_valid = 1'b1; s_state = FIPS; s_final = 1'b0;
    tick();
    s_valid = 1'b0;
    expect_beat("t4_a0", FC0, 2'd0, 1'b0, 1'b0);
    tick(); expect_beat("t4_a1", FC1, 2'd1, 1'b0, 1'b0);
    tick(); expect_beat("t4_a2", FC2, 2'd2, 1'b0, 1'b0);
    tick(); expect_beat("t4_a3", FC3, 2'd3, 1'b1, 1'b0);
    s_valid = 1'b1; s_state = '0; s_final = 1'b1;
    #1;
    chk("t4_sready_last", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0; s_final = 1'b0;
    expect_beat("t4_b0", ZC, 2'd0, 1'b0, 1'b1);
    tick(); expect_beat("t4_b1", ZC, 2'd1, 1'b0, 1'b1);
    tick(); expect_beat("t4_b2", ZC, 2'd2, 1'b0, 1'b1);
    tick(); expect_beat("t4_b3", ZC, 2'd3, 1'b1, 1'b1);
    tick();
    chk("t4_idle_mvalid", 32'(m_valid), 32'd0);

    // 5: asynchronous reset while column 2 is presented
    s_valid = 1'b1; s_state = FIPS; s_final = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    expect_beat("t5_b2", FC2, 2'd2, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_mvalid", 32'(m_valid),  32'd0);
    chk("t5_rst_col",    o_column,       32'd0);
    chk("t5_rst_idx",    32'(o_col_idx), 32'd0);
    chk("t5_rst_final",  32'(o_final),   32'd0);
    tick();
    rst = 1'b0;
    chk("t5_rel_sready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_stale", 32'(m_valid), 32'd0);
    end

    // 6: random states with random source gaps and sink stalls
    sent = 0; beats = 0; cyc = 0;
    while ((sent < N || q.size() != 0) && cyc < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid && sent < N && $urandom_range(0, 2) != 0) begin
        s_state = {$urandom, $urandom, $urandom, $urandom};
        s_final = 1'($urandom_range(0, 1));
        s_valid = 1'b1;
      end
      #1;
      if (m_valid && m_ready) begin
        beats++;
        exp_col = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
        chk("rnd_col", o_column, exp_col);
      end
      acc = s_valid && s_ready;
      if (acc) begin
        for (int c = 0; c < 4; c++) q.push_back(model_col(s_state, c));
        sent++;
      end
      tick();
      cyc++;
      if (acc) s_valid = 1'b0;
    end
    chk("rnd_timeout", 32'(cyc < 3000), 32'd1);
    chk("rnd_beats",   32'(beats),      32'(4 * N));
    tick();
    chk("rnd_end_mvalid", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
